// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execution unit and ALU control: operation codes,
// FSM state encoding and default widths.
package alu_exec_unit_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned SHW_DEF  = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } sh_kind_e;

    function automatic logic is_shift(input logic [3:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_shifter.sv
// One-bit-per-cycle shifter: working register, down-counter and fill-bit logic.
// done_c marks the cycle whose shift (dout_c) is the final one.
module alu_serial_shifter
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned SHW  = SHW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            load,
    input  sh_kind_e        kind,
    input  logic [XLEN-1:0] din,
    input  logic [SHW-1:0]  amt,
    output logic            done_c,
    output logic [XLEN-1:0] dout_c
);

    logic [XLEN-1:0] shreg_q, shreg_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    sh_kind_e        kind_q, kind_d;
    logic            fill_c;
    logic [XLEN-1:0] step_c;

    // Single-bit step; SRA replicates the sign bit, the others fill with zero
    always_comb begin
        fill_c = (kind_q == SH_SRA) && shreg_q[XLEN-1];
        case (kind_q)
            SH_SLL:  step_c = {shreg_q[XLEN-2:0], 1'b0};
            default: step_c = {fill_c, shreg_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        if (flush) begin
            cnt_d = '0;
        end else if (load) begin
            shreg_d = din;
            cnt_d   = amt;
            kind_d  = kind;
        end else if (cnt_q != '0) begin
            shreg_d = step_c;
            cnt_d   = cnt_q - SHW'(1);
        end
    end

    assign done_c = !flush && (cnt_q == SHW'(1));
    assign dout_c = step_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            kind_q  <= SH_SLL;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle logic/arith/compare ops, iterative shifts,
// valid/ready on both sides with a registered result and flags.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned SHW  = SHW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALU_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    logic            accept_c;
    logic            shift_c;
    logic            sh_load_c;
    sh_kind_e        sh_kind_c;
    logic [SHW-1:0]  sh_amt_c;
    logic            sh_done_c;
    logic [XLEN-1:0] sh_res_c;
    logic [XLEN-1:0] alu_res_c;
    logic            alu_ill_c;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept_c  = in_valid && in_ready && !flush;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    assign sh_amt_c = op_b[SHW-1:0];
    assign shift_c  = is_shift(ALU_sel) && (sh_amt_c != '0);

    // Single-cycle datapath; a zero-amount shift passes op_a straight through
    always_comb begin
        alu_res_c = '0;
        alu_ill_c = 1'b0;
        sh_kind_c = SH_SRL;
        case (ALU_sel)
            ALU_AND:  alu_res_c = op_a & op_b;
            ALU_OR:   alu_res_c = op_a | op_b;
            ALU_ADD:  alu_res_c = op_a + op_b;
            ALU_SUB:  alu_res_c = op_a - op_b;
            ALU_XOR:  alu_res_c = op_a ^ op_b;
            ALU_SLT:  alu_res_c = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_res_c = XLEN'(op_a < op_b);
            ALU_SLL: begin
                alu_res_c = op_a;
                sh_kind_c = SH_SLL;
            end
            ALU_SRL: begin
                alu_res_c = op_a;
                sh_kind_c = SH_SRL;
            end
            ALU_SRA: begin
                alu_res_c = op_a;
                sh_kind_c = SH_SRA;
            end
            default:  alu_ill_c = 1'b1;
        endcase
    end

    // Next state and result capture; flush wins over any accept
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        sh_load_c = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept_c) begin
                        if (shift_c) begin
                            state_d   = ST_SHIFT;
                            sh_load_c = 1'b1;
                        end else begin
                            state_d   = ST_DONE;
                            result_d  = alu_res_c;
                            zero_d    = (alu_res_c == '0);
                            illegal_d = alu_ill_c;
                        end
                    end else if ((state_q == ST_DONE) && out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (sh_done_c) begin
                        state_d   = ST_DONE;
                        result_d  = sh_res_c;
                        zero_d    = (sh_res_c == '0);
                        illegal_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    alu_serial_shifter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .load   (sh_load_c),
        .kind   (sh_kind_c),
        .din    (op_a),
        .amt    (sh_amt_c),
        .done_c (sh_done_c),
        .dout_c (sh_res_c)
    );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against an operator-level reference model.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALU_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALU_sel   (ALU_sel),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the operation table
    function automatic void model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        logic [4:0] sh;
        sh  = b[4:0];
        ill = 1'b0;
        lat = 1;
        case (sel)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0100: r = a ^ b;
            4'b0111: begin r = a << sh; lat = int'(sh) + 1; end
            4'b1000: begin r = a >> sh; lat = int'(sh) + 1; end
            4'b1001: begin r = 32'($signed(a) >>> sh); lat = int'(sh) + 1; end
            4'b1010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1011: r = (a < b) ? 32'd1 : 32'd0;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    // One op with out_ready held high: checks accept, latency, stall length and result
    task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_r;
        logic        exp_ill;
        int          exp_lat;
        int          cyc;
        int          stalls;
        model(sel, a, b, exp_r, exp_ill, exp_lat);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        ALU_sel   = sel;
        op_a      = a;
        op_b      = b;
        #1;
        check_eq("accept_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        ALU_sel  = 4'($urandom_range(0, 15));
        op_a     = $urandom;
        op_b     = $urandom;
        cyc      = 1;
        stalls   = 0;
        while (!out_valid && cyc < 100) begin
            if (!in_ready) stalls++;
            @(negedge clk);
            cyc++;
        end
        check_eq("latency", 32'(cyc), 32'(exp_lat));
        check_eq("stall_cycles", 32'(stalls), 32'(exp_lat - 1));
        check_eq("result", result, exp_r);
        check_eq("zero", 32'(zero), 32'(exp_r == 32'd0));
        check_eq("illegal", 32'(illegal), 32'(exp_ill));
    endtask

    task automatic watch_no_valid(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check_eq(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ALU_sel   = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_zero", 32'(zero), 32'd0);
        check_eq("rst_illegal", 32'(illegal), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        run_op(4'b0010, 32'h7FFF_FFFF, 32'd1);

        // Back-to-back SUB then SLTU
        @(negedge clk);
        in_valid = 1'b1; ALU_sel = 4'b0110; op_a = 32'd5; op_b = 32'd5;
        @(negedge clk);
        check_eq("b2b_valid0", 32'(out_valid), 32'd1);
        check_eq("b2b_res0", result, 32'd0);
        check_eq("b2b_zero0", 32'(zero), 32'd1);
        check_eq("b2b_ready", 32'(in_ready), 32'd1);
        ALU_sel = 4'b1011; op_a = 32'd1; op_b = 32'hFFFF_FFFF;
        @(negedge clk);
        check_eq("b2b_valid1", 32'(out_valid), 32'd1);
        check_eq("b2b_res1", result, 32'd1);
        check_eq("b2b_zero1", 32'(zero), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b_idle", 32'(out_valid), 32'd0);

        run_op(4'b1001, 32'h8000_0000, 32'd31);
        run_op(4'b1000, 32'h8000_0000, 32'd31);
        run_op(4'b0111, 32'h0000_0001, 32'd0);
        run_op(4'b0111, 32'hDEAD_BEEF, 32'hFFFF_FFE4);

        // Result held while downstream stalls; new offers ignored
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0; ALU_sel = 4'b0111; op_a = 32'd1; op_b = 32'd0;
        @(negedge clk);
        ALU_sel = 4'b0010; op_a = 32'd7; op_b = 32'd8;
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_result", result, 32'd1);
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check_eq("hold_release", 32'(out_valid), 32'd0);

        run_op(4'b0011, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op(4'b0010, 32'd3, 32'd4);

        // Flush mid-shift together with an offered op
        @(negedge clk);
        in_valid = 1'b1; ALU_sel = 4'b0111; op_a = 32'd1; op_b = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; ALU_sel = 4'b0010; op_a = 32'd2; op_b = 32'd3;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_valid", 32'(out_valid), 32'd0);
        check_eq("flush_in_ready", 32'(in_ready), 32'd1);
        watch_no_valid("flush_no_valid", 30);

        // Flush in IDLE drops the simultaneous accept
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; ALU_sel = 4'b0010; op_a = 32'd2; op_b = 32'd3;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        watch_no_valid("flush_drop", 4);
        check_eq("flush_keeps_result", result, 32'd7);

        // Reset during a shift
        @(negedge clk);
        in_valid = 1'b1; ALU_sel = 4'b1000; op_a = 32'hF0F0_F0F0; op_b = 32'd25;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst2_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst2_result", result, 32'd0);
        check_eq("rst2_zero", 32'(zero), 32'd0);
        check_eq("rst2_illegal", 32'(illegal), 32'd0);
        check_eq("rst2_in_ready", 32'(in_ready), 32'd1);
        watch_no_valid("rst2_no_valid", 30);

        // Random operations
        for (int n = 0; n < 150; n++) begin
            logic [3:0]  s;
            logic [31:0] a;
            logic [31:0] b;
            s = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            run_op(s, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
